// File: rtl/d_grf_scb_if.sv
`default_nettype none
// ============================================================================
// Module   : d_grf_scb_if
// Purpose  : Bundles the write, read, allocation and status signals of the
//            decode-stage register file with pending-write scoreboard.
//            The master drives writes, reads and allocs. The slave (the
//            register file) returns read data, ready flags and overflow.
// Signals  : we/wa/wd/w_pc   write port (W stage)
//            ra / rd / rv    NR read ports, packed per port
//            alloc_en/alloc_a producer allocation (D-stage issue)
//            flush           clear all outstanding counts
//            ovf             sticky counter-saturation flag
// Revision : 1.0  initial release
// ============================================================================
interface d_grf_scb_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [31:0]       w_pc;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rv;
    logic              alloc_en;
    logic [AW-1:0]     alloc_a;
    logic              flush;
    logic              ovf;

    modport master (
        output we, wa, wd, w_pc, ra, alloc_en, alloc_a, flush,
        input  rd, rv, ovf
    );

    modport slave (
        input  we, wa, wd, w_pc, ra, alloc_en, alloc_a, flush,
        output rd, rv, ovf
    );
endinterface
`default_nettype wire

// File: rtl/d_grf_scb.sv
`default_nettype none
// ============================================================================
// Module   : d_grf_scb
// Purpose  : Decode-stage general register file with a per-register
//            outstanding-producer scoreboard. NR combinational read ports
//            with write-to-read bypass, one write port, one alloc port.
// Ports    : clk    rising-edge clock
//            reset  synchronous, active-high
//            bus    d_grf_scb_if.slave (write/read/alloc/flush/ovf)
// Options  : GRF_TRACE_EN  when defined, prints one trace line per
//            register write (including writes to a hardwired zero reg).
// Revision : 1.0  initial release
// ============================================================================
module d_grf_scb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int CW       = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    d_grf_scb_if.slave   bus
);
    localparam int            DEPTH     = 1 << AW;
    localparam bit            C_ZR      = (ZERO_REG != 0);
    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic [DW-1:0] r_regs [DEPTH];
    logic [CW-1:0] r_cnt  [DEPTH];
    logic          r_ovf;

    logic w_wa_zero;      // write targets the hardwired zero register
    logic w_wr_ok;        // write actually changes the array / may bypass
    logic w_dec_en;       // write retires a producer (counter decrement)
    logic w_alloc_ok;     // allocation that can touch a counter
    logic w_alloc_wr_eq;  // alloc and retire on the same register cancel out
    logic w_ovf_set;

    assign w_wa_zero     = C_ZR && (bus.wa == '0);
    assign w_wr_ok       = bus.we && !reset && !w_wa_zero;
    assign w_dec_en      = bus.we && !reset;
    assign w_alloc_ok    = bus.alloc_en && !reset && !(C_ZR && (bus.alloc_a == '0));
    assign w_alloc_wr_eq = w_dec_en && (bus.wa == bus.alloc_a);
    // Flush discards the allocation, so it cannot overflow either.
    assign w_ovf_set     = w_alloc_ok && !bus.flush && !w_alloc_wr_eq &&
                           (r_cnt[bus.alloc_a] == C_CNT_MAX);

    // Register array
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Outstanding-producer counters. Increments saturate, decrements floor
    // at zero; a simultaneous alloc and retire on one register is a no-op.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset || bus.flush || (C_ZR && (i == 0))) begin
                r_cnt[i] <= '0;
            end else begin
                if (w_alloc_ok && (bus.alloc_a == AW'(i)) &&
                    !(w_dec_en && (bus.wa == AW'(i)))) begin
                    if (r_cnt[i] != C_CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else if (w_dec_en && (bus.wa == AW'(i)) &&
                             !(w_alloc_ok && (bus.alloc_a == AW'(i)))) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;

    // Read ports
    for (genvar p = 0; p < NR; p++) begin : g_rd_port
        logic [AW-1:0] w_ra;
        logic          w_byp;
        logic [CW-1:0] w_cnt;

        assign w_ra  = bus.ra[p*AW +: AW];
        assign w_byp = w_wr_ok && (bus.wa == w_ra);
        assign w_cnt = r_cnt[w_ra];

        assign bus.rd[p*DW +: DW] = (C_ZR && (w_ra == '0)) ? '0 :
                                    w_byp                  ? bus.wd :
                                                             r_regs[w_ra];
        // A last outstanding producer writing back this cycle already
        // supplies the operand through the bypass.
        assign bus.rv[p] = reset || (w_cnt == '0) ||
                           ((w_cnt == CW'(1)) && w_byp);
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (bus.we && !reset) begin
            $display("%d@%h: $%d <= %h", $time, bus.w_pc, bus.wa, bus.wd);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^bus.w_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_grf_scb.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_grf_scb
// Purpose  : Directed self-checking bench for d_grf_scb (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_d_grf_scb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    d_grf_scb_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

    d_grf_scb #(
        .DW(DW), .AW(AW), .NR(NR), .CW(2), .ZERO_REG(1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.alloc_en = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.we       = 1'b0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.w_pc     = 32'h0000_1000;
        bus.ra       = '0;
        bus.alloc_en = 1'b0;
        bus.alloc_a  = '0;
        bus.flush    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state on every address, both ports
        for (int a = 0; a < 32; a++) begin
            set_ra(AW'(a), AW'(31 - a));
            #1;
            check("rst_rd", 64'(bus.rd), 64'd0);
            check("rst_rv", 64'(bus.rv), 64'd3);
        end
        check("rst_ovf", 64'(bus.ovf), 64'd0);

        // Write with same-cycle bypass, then array read
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
        set_ra(5'd5, 5'd6);
        #1;
        check("byp_rd0", 64'(bus.rd[31:0]), 64'hDEADBEEF);
        check("byp_rd1", 64'(bus.rd[63:32]), 64'd0);
        check("byp_rv", 64'(bus.rv), 64'd3);
        tick();
        bus.we = 1'b0;
        #1;
        check("arr_rd0", 64'(bus.rd[31:0]), 64'hDEADBEEF);

        // Writes to register 0 are discarded, no bypass
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'd1;
        set_ra(5'd0, 5'd0);
        #1;
        check("r0_byp", 64'(bus.rd), 64'd0);
        tick();
        bus.we = 1'b0;
        #1;
        check("r0_arr", 64'(bus.rd), 64'd0);

        // Two producers for r7, retired one at a time
        bus.alloc_en = 1'b1; bus.alloc_a = 5'd7;
        tick();
        tick();
        bus.alloc_en = 1'b0;
        set_ra(5'd7, 5'd7);
        #1;
        check("r7_cnt2", 64'(bus.rv), 64'd0);
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'd77;
        #1;
        check("r7_cnt2_wr", 64'(bus.rv), 64'd0);
        tick();
        bus.we = 1'b0;
        #1;
        check("r7_cnt1", 64'(bus.rv), 64'd0);
        bus.we = 1'b1; bus.wd = 32'd88;
        #1;
        check("r7_cnt1_byp_rv", 64'(bus.rv), 64'd3);
        check("r7_cnt1_byp_rd", 64'(bus.rd), {32'd88, 32'd88});
        tick();
        bus.we = 1'b0;
        #1;
        check("r7_cnt0_rv", 64'(bus.rv), 64'd3);
        check("r7_cnt0_rd", 64'(bus.rd[31:0]), 64'd88);

        // Saturation on r3 and sticky overflow
        set_ra(5'd3, 5'd5);
        bus.alloc_en = 1'b1; bus.alloc_a = 5'd3;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("r3_alloc_rv", 64'(bus.rv), 64'b10);
            check("r3_alloc_ovf", 64'(bus.ovf), 64'd0);
        end
        tick();
        check("r3_ovf_set", 64'(bus.ovf), 64'd1);
        // Alloc and retire on r3 together: count stays at 3
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h33;
        tick();
        bus.alloc_en = 1'b0;
        tick();   // 3 -> 2
        tick();   // 2 -> 1
        bus.we = 1'b0;
        #1;
        check("r3_cnt1", 64'(bus.rv[0]), 64'd0);
        check("r3_ovf_hold", 64'(bus.ovf), 64'd1);
        bus.we = 1'b1;
        #1;
        check("r3_cnt1_byp", 64'(bus.rv[0]), 64'd1);
        tick();
        bus.we = 1'b0;
        #1;
        check("r3_cnt0", 64'(bus.rv[0]), 64'd1);

        // Flush overrides alloc and decrement, keeps write and ovf
        bus.alloc_en = 1'b1; bus.alloc_a = 5'd9;
        tick();
        tick();
        bus.alloc_en = 1'b0;
        set_ra(5'd9, 5'd7);
        #1;
        check("r9_cnt2", 64'(bus.rv), 64'b10);
        bus.flush = 1'b1;
        bus.alloc_en = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'd5;
        tick();
        idle();
        #1;
        check("flush_rv", 64'(bus.rv), 64'd3);
        check("flush_rd", 64'(bus.rd[31:0]), 64'd5);
        check("flush_ovf", 64'(bus.ovf), 64'd1);

        // Reset in the middle of activity
        bus.alloc_en = 1'b1; bus.alloc_a = 5'd12;
        tick();
        tick();
        bus.alloc_en = 1'b0;
        set_ra(5'd12, 5'd5);
        #1;
        check("r12_cnt2", 64'(bus.rv), 64'b10);
        reset = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 32'hAA;
        bus.alloc_en = 1'b1;
        #1;
        check("inrst_rd0", 64'(bus.rd[31:0]), 64'd0);
        check("inrst_rd1", 64'(bus.rd[63:32]), 64'hDEADBEEF);
        check("inrst_rv", 64'(bus.rv), 64'd3);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("postrst_ovf", 64'(bus.ovf), 64'd0);
        for (int a = 0; a < 32; a++) begin
            set_ra(AW'(a), AW'(a ^ 1));
            #1;
            check("postrst_rd", 64'(bus.rd), 64'd0);
            check("postrst_rv", 64'(bus.rv), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
